seven_segment_scanner: RTL and testbench

Parametrised, time-multiplexed driver for an N-digit seven-segment display with decimal points, selectable anode/cathode polarity, PWM brightness, an anti-ghosting dead phase and optional leading-zero blanking. It sits between the register/counter logic that produces packed BCD/hex nibbles and the FPGA pins driving segment and digit lines. It supersedes the fixed-polarity, always-on multiplexed driver.

---
 rtl/seven_segment_pkg.sv | 40 ++++
 rtl/seven_segment_font.sv | 15 +
 rtl/seven_segment_scanner.sv | 145 ++++++++++++++
 tb/tb_seven_segment_scanner.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the multiplexed seven-segment driver: glyph table,
// blank pattern, scan state type and the digit-select width helper.
package seven_segment_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  // {G,F,E,D,C,B,A}, active-low (common-anode) encoding.
  localparam logic [6:0] BLANK_CA = 7'h7F;

  function automatic logic [6:0] glyph_ca(input logic [3:0] value);
    logic [6:0] g;
    case (value)
      4'h0:    g = 7'h40;
      4'h1:    g = 7'h79;
      4'h2:    g = 7'h24;
      4'h3:    g = 7'h30;
      4'h4:    g = 7'h19;
      4'h5:    g = 7'h12;
      4'h6:    g = 7'h02;
      4'h7:    g = 7'h78;
      4'h8:    g = 7'h00;
      4'h9:    g = 7'h10;
      4'hA:    g = 7'h08;
      4'hB:    g = 7'h03;
      4'hC:    g = 7'h46;
      4'hD:    g = 7'h21;
      4'hE:    g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seven_segment_font.sv
// Combinational hex glyph lookup, emitted in the polarity of the segment pins.
module seven_segment_font
  import seven_segment_pkg::*;
#(
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = COMMON_ANODE ? glyph_ca(code) : ~glyph_ca(code);
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed N-digit seven-segment driver with PWM brightness, a dead
// phase per digit slot, per-frame input snapshots and leading-zero blanking.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int DIGITS           = 4,
  parameter int PRESCALE_BITS    = 16,
  parameter int BRIGHT_BITS      = 4,
  parameter bit COMMON_ANODE     = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING    = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [4*DIGITS-1:0]            code,
  input  logic [DIGITS-1:0]              points,
  input  logic [BRIGHT_BITS-1:0]         brightness,
  output logic [7:0]                     segments,
  output logic [DIGITS-1:0]              digit_en,
  output logic [sel_width(DIGITS)-1:0]   sel,
  output logic                           frame
);

  localparam int                SW        = sel_width(DIGITS);
  localparam logic [7:0]        SEG_OFF   = {8{COMMON_ANODE}};
  localparam logic [DIGITS-1:0] EN_OFF    = {DIGITS{DIGIT_ACTIVE_LOW}};
  localparam logic [6:0]        BLANK_PAT = COMMON_ANODE ? BLANK_CA : ~BLANK_CA;

  scan_state_t              state_reg;
  logic [PRESCALE_BITS-1:0] prescale_reg;
  logic [BRIGHT_BITS-1:0]   phase_reg;
  logic [SW-1:0]            sel_reg;
  logic [4*DIGITS-1:0]      code_snap_reg;
  logic [DIGITS-1:0]        points_snap_reg;
  logic [BRIGHT_BITS-1:0]   bright_snap_reg;

  logic [3:0]        nibble [DIGITS];
  logic [DIGITS-1:0] blank;

  // A digit is blanked when it and every more-significant nibble are zero.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign nibble[gi] = code_snap_reg[4*gi +: 4];
    if (gi == 0 || !BLANK_LEADING) begin : g_keep
      assign blank[gi] = 1'b0;
    end else begin : g_lz
      assign blank[gi] = (code_snap_reg[4*DIGITS-1:4*gi] == '0);
    end
  end

  logic [6:0] glyph;

  seven_segment_font #(
    .COMMON_ANODE(COMMON_ANODE)
  ) u_font (
    .code   (nibble[sel_reg]),
    .pattern(glyph)
  );

  logic              lit;
  logic              tick;
  logic              phase_wrap;
  logic              frame_wrap;
  logic [7:0]        seg_next;
  logic [DIGITS-1:0] en_next;
  logic              frame_next;

  always_comb begin
    tick       = &prescale_reg;
    phase_wrap = tick && (&phase_reg);
    frame_wrap = phase_wrap && (sel_reg == SW'(DIGITS - 1));
    // Phase 0 is the anti-ghosting gap; later phases form the PWM duty.
    lit        = (phase_reg != '0) && (phase_reg <= bright_snap_reg);
    frame_next = (prescale_reg == '0) && (phase_reg == '0) && (sel_reg == '0);
    seg_next   = SEG_OFF;
    en_next    = EN_OFF;
    if (lit) begin
      seg_next = {points_snap_reg[sel_reg] ^ COMMON_ANODE,
                  blank[sel_reg] ? BLANK_PAT : glyph};
      en_next  = (DIGITS'(1) << sel_reg) ^ EN_OFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      prescale_reg    <= '0;
      phase_reg       <= '0;
      sel_reg         <= '0;
      code_snap_reg   <= '0;
      points_snap_reg <= '0;
      bright_snap_reg <= '0;
      segments        <= SEG_OFF;
      digit_en        <= EN_OFF;
      sel             <= '0;
      frame           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          prescale_reg <= '0;
          phase_reg    <= '0;
          sel_reg      <= '0;
          segments     <= SEG_OFF;
          digit_en     <= EN_OFF;
          sel          <= '0;
          frame        <= 1'b0;
          if (enable) begin
            state_reg       <= SCAN;
            code_snap_reg   <= code;
            points_snap_reg <= points;
            bright_snap_reg <= brightness;
          end
        end
        SCAN: begin
          if (!enable) begin
            state_reg    <= IDLE;
            prescale_reg <= '0;
            phase_reg    <= '0;
            sel_reg      <= '0;
            segments     <= SEG_OFF;
            digit_en     <= EN_OFF;
            sel          <= '0;
            frame        <= 1'b0;
          end else begin
            segments     <= seg_next;
            digit_en     <= en_next;
            sel          <= sel_reg;
            frame        <= frame_next;
            prescale_reg <= prescale_reg + PRESCALE_BITS'(1);
            if (tick) phase_reg <= phase_reg + BRIGHT_BITS'(1);
            if (phase_wrap) sel_reg <= frame_wrap ? '0 : sel_reg + SW'(1);
            // Inputs are captured only as the counters roll into a new frame.
            if (frame_wrap) begin
              code_snap_reg   <= code;
              points_snap_reg <= points;
              bright_snap_reg <= brightness;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench: directed vector table, hand-written timing sequences and
// a randomized run against a frame-position reference model.
module tb_seven_segment_scanner;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] code;
  logic [3:0]  points;
  logic [1:0]  brightness;
  logic [7:0]  segments;
  logic [3:0]  digit_en;
  logic [1:0]  sel;
  logic        frame;

  int checks = 0;
  int errors = 0;

  localparam logic [14:0] INACT = {8'hFF, 4'hF, 2'b00, 1'b0};

  always #5 clk = ~clk;

  seven_segment_scanner #(
    .DIGITS(4), .PRESCALE_BITS(2), .BRIGHT_BITS(2),
    .COMMON_ANODE(1'b1), .DIGIT_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .code(code), .points(points),
    .brightness(brightness), .segments(segments), .digit_en(digit_en),
    .sel(sel), .frame(frame)
  );

  logic [14:0] obs;
  assign obs = {segments, digit_en, sel, frame};

  function automatic logic [7:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // Expected {segments, digit_en, sel, frame} for output position pos (0..63) of a frame.
  function automatic logic [14:0] expect_at(input int pos, input logic [15:0] c,
                                            input logic [3:0] p, input logic [1:0] b);
    int d;
    int ph;
    logic [7:0] s;
    logic [3:0] e;
    d  = pos / 16;
    ph = (pos % 16) / 4;
    s  = 8'hFF;
    e  = 4'hF;
    if (ph != 0 && ph <= int'(b)) begin
      e = ~(4'b0001 << d);
      if (d > 0 && (c >> (4 * d)) == 16'h0) s = 8'hFF;
      else s = hex_glyph(c[4*d +: 4]);
      if (p[d]) s[7] = 1'b0;
    end
    return {s, e, 2'(d), pos == 0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [15:0] c, input logic [3:0] p, input logic [1:0] b);
    code = c;
    points = p;
    brightness = b;
  endtask

  // Returns at the negedge where frame is first seen high (output position 0).
  task automatic wait_frame();
    int n;
    n = 0;
    @(negedge clk);
    while (frame !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (frame !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: frame=%b after 200 clk, required 1", frame);
    end
  endtask

  typedef struct {
    logic [15:0] code;
    logic [3:0]  pts;
    logic [1:0]  br;
    int          off;
    logic [7:0]  seg;
    logic [3:0]  en;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [15:0] c, input logic [3:0] p, input logic [1:0] b,
                     input int off, input logic [7:0] s, input logic [3:0] e);
    vec_t v;
    v.code = c; v.pts = p; v.br = b; v.off = off; v.seg = s; v.en = e;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act_cnt;
    int frm_cnt;
    bit          m_scan;
    int          m_pos;
    logic [15:0] s_code;
    logic [3:0]  s_pts;
    logic [1:0]  s_br;
    logic [14:0] exp_v;

    rst = 1'b1;
    enable = 1'b0;
    set_in(16'h0, 4'h0, 2'd0);
    @(negedge clk);
    check("reset_state", 32'(obs), 32'(INACT));
    rst = 1'b0;
    enable = 1'b1;

    add(16'h1234, 4'b0000, 2'd3,  0, 8'hFF, 4'hF);
    add(16'h1234, 4'b0000, 2'd3,  4, 8'h99, 4'hE);
    add(16'h1234, 4'b0000, 2'd3, 15, 8'h99, 4'hE);
    add(16'h1234, 4'b0000, 2'd3, 16, 8'hFF, 4'hF);
    add(16'h1234, 4'b0000, 2'd3, 20, 8'hB0, 4'hD);
    add(16'h0005, 4'b0100, 2'd3,  4, 8'h92, 4'hE);
    add(16'h0005, 4'b0100, 2'd3, 20, 8'hFF, 4'hD);
    add(16'h0005, 4'b0100, 2'd3, 36, 8'h7F, 4'hB);
    add(16'h0005, 4'b0100, 2'd3, 52, 8'hFF, 4'h7);
    add(16'h0000, 4'b0000, 2'd3,  4, 8'hC0, 4'hE);
    add(16'h0000, 4'b0000, 2'd3, 20, 8'hFF, 4'hD);
    add(16'h1234, 4'b0000, 2'd1,  4, 8'h99, 4'hE);
    add(16'h1234, 4'b0000, 2'd1,  8, 8'hFF, 4'hF);
    add(16'h1234, 4'b0000, 2'd0,  4, 8'hFF, 4'hF);
    add(16'hABCD, 4'b0000, 2'd3,  4, 8'hA1, 4'hE);
    add(16'hABCD, 4'b0000, 2'd3, 20, 8'hC6, 4'hD);
    add(16'hABCD, 4'b0000, 2'd3, 36, 8'h83, 4'hB);
    add(16'hABCD, 4'b0000, 2'd3, 52, 8'h88, 4'h7);

    foreach (vecs[i]) begin
      set_in(vecs[i].code, vecs[i].pts, vecs[i].br);
      wait_frame();
      repeat (vecs[i].off) @(negedge clk);
      check($sformatf("vec%0d", i), 32'({segments, digit_en, sel}),
            32'({vecs[i].seg, vecs[i].en, 2'(vecs[i].off / 16)}));
      $display("vec %0d: code=%h pts=%b br=%0d off=%0d seg=%h en=%h", i,
               vecs[i].code, vecs[i].pts, vecs[i].br, vecs[i].off, segments, digit_en);
    end

    // Asynchronous reset in the middle of a lit phase.
    set_in(16'h1234, 4'h0, 2'd3);
    wait_frame();
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_reset", 32'(obs), 32'(INACT));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_release_idle", 32'(obs), 32'(INACT));
    @(negedge clk);
    check("reset_resume_frame", 32'(obs), 32'({8'hFF, 4'hF, 2'b00, 1'b1}));
    $display("seq reset: resumed with frame=%b sel=%0d", frame, sel);

    // Brightness 1: 4 lit clk per 16-clk slot.
    set_in(16'h1234, 4'h0, 2'd1);
    wait_frame();
    act_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      if (digit_en != 4'hF) act_cnt++;
      @(negedge clk);
    end
    check("bright1_lit_clk", 32'(act_cnt), 32'd16);

    // Brightness 0: never lit, frame still every 64 clk.
    set_in(16'h1234, 4'h0, 2'd0);
    wait_frame();
    act_cnt = 0;
    frm_cnt = 0;
    for (int k = 0; k < 128; k++) begin
      if (digit_en != 4'hF) act_cnt++;
      if (frame) frm_cnt++;
      @(negedge clk);
    end
    check("bright0_lit_clk", 32'(act_cnt), 32'd0);
    check("bright0_frames", 32'(frm_cnt), 32'd2);
    $display("seq brightness: br0 lit=%0d frames=%0d", act_cnt, frm_cnt);

    // Mid-frame code change only applies from the next frame.
    set_in(16'h1234, 4'h0, 2'd3);
    wait_frame();
    repeat (32) @(negedge clk);
    code = 16'hABCD;
    repeat (4) @(negedge clk);
    check("snap_digit2_old", 32'({segments, digit_en}), 32'({8'hA4, 4'hB}));
    repeat (16) @(negedge clk);
    check("snap_digit3_old", 32'({segments, digit_en}), 32'({8'hF9, 4'h7}));
    repeat (12) @(negedge clk);
    check("snap_next_frame", 32'(frame), 32'd1);
    repeat (4) @(negedge clk);
    check("snap_digit0_new", 32'({segments, digit_en}), 32'({8'hA1, 4'hE}));
    $display("seq snapshot: next frame digit0 seg=%h", segments);

    // Enable dropped for 10 clk mid-frame.
    set_in(16'h1234, 4'h0, 2'd3);
    wait_frame();
    repeat (20) @(negedge clk);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("disabled_clk%0d", k), 32'(obs), 32'(INACT));
    end
    enable = 1'b1;
    @(negedge clk);
    check("reenable_idle_exit", 32'(obs), 32'(INACT));
    @(negedge clk);
    check("reenable_frame", 32'(obs), 32'({8'hFF, 4'hF, 2'b00, 1'b1}));
    $display("seq enable: restart frame=%b sel=%0d", frame, sel);

    // Randomized run against the frame-position model, starting from IDLE.
    enable = 1'b0;
    repeat (2) @(negedge clk);
    m_scan = 1'b0;
    m_pos = 0;
    s_code = 16'h0;
    s_pts = 4'h0;
    s_br = 2'd0;
    exp_v = INACT;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      check($sformatf("rand_cyc%0d", cyc), 32'(obs), 32'(exp_v));
      if (enable ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 7) == 0))
        enable = ~enable;
      if ($urandom_range(0, 29) == 0) begin
        code = 16'($urandom);
        if ($urandom_range(0, 2) == 0) code = code & 16'h00FF;
        if ($urandom_range(0, 3) == 0) code = code & 16'h000F;
      end
      if ($urandom_range(0, 29) == 0) points = 4'($urandom);
      if ($urandom_range(0, 29) == 0) brightness = 2'($urandom);
      if (!m_scan) begin
        exp_v = INACT;
        if (enable) begin
          m_scan = 1'b1;
          m_pos = 0;
          s_code = code; s_pts = points; s_br = brightness;
        end
      end else if (!enable) begin
        exp_v = INACT;
        m_scan = 1'b0;
      end else begin
        exp_v = expect_at(m_pos, s_code, s_pts, s_br);
        m_pos = (m_pos + 1) % 64;
        if (m_pos == 0) begin
          s_code = code; s_pts = points; s_br = brightness;
        end
      end
      @(negedge clk);
      if (cyc % 250 == 249) $display("random block %0d: errors so far %0d", cyc / 250, errors);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
